// File: rtl/axis_video_out_if.sv
// AXI-Stream pixel link into axis_video_out: TUSER marks start of frame,
// TLAST marks end of line.
interface axis_video_out_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tuser;
  logic                  tlast;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_out.sv
// Pixel-domain video output stage: buffers an AXI-Stream frame in a FIFO and
// locks it to an external timing generator, resyncing on underflow/misalignment.
module axis_video_out #(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    FIFO_DEPTH      = 1024,
  parameter int                    UNDERFLOW_MODE  = 0,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 16'hF81F,
  parameter logic [DATA_WIDTH-1:0] IDLE_COLOR      = 16'h0000
) (
  input  logic                  pix_clk,
  input  logic                  pix_rst,
  axis_video_out_if.slave       s_axis,
  input  logic                  tim_de,
  input  logic                  tim_hs,
  input  logic                  tim_vs,
  input  logic                  tim_sof,
  input  logic                  tim_eol,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_de,
  output logic                  vid_hs,
  output logic                  vid_vs,
  output logic                  locked,
  output logic [15:0]           underflow_count,
  output logic [15:0]           resync_count,
  output logic [31:0]           pixel_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SEEK, PRIME, RUN, FLUSH} state_t;

  state_t                r_state, w_nxt;
  logic [DATA_WIDTH+1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_vid_data;
  logic                  r_vid_de, r_vid_hs, r_vid_vs, r_locked;
  logic [15:0]           r_uf_cnt, r_rs_cnt;
  logic [31:0]           r_pix_cnt;

  logic                  w_empty, w_full, w_tready, w_wr, w_rd;
  logic                  w_flush, w_uf, w_rs;
  logic [DATA_WIDTH+1:0] w_head;
  logic [DATA_WIDTH-1:0] w_pix;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rptr];

  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      SEEK:       w_tready = 1'b1;
      PRIME, RUN: w_tready = ~w_full;
      default:    w_tready = 1'b0;
    endcase
  end

  // Gate with reset so the stream sees tready low for the whole reset pulse.
  assign s_axis.tready = w_tready & ~pix_rst;
  // In SEEK only the start-of-frame beat is stored; everything before it is dropped.
  assign w_wr = s_axis.tvalid & w_tready & ((r_state != SEEK) | s_axis.tuser);

  always_comb begin
    w_nxt   = r_state;
    w_rd    = 1'b0;
    w_flush = 1'b0;
    w_uf    = 1'b0;
    w_rs    = 1'b0;
    w_pix   = IDLE_COLOR;
    case (r_state)
      SEEK: if (w_wr) w_nxt = PRIME;
      PRIME: begin
        if (tim_de && tim_sof && !w_empty && w_head[DATA_WIDTH+1]) begin
          w_rd  = 1'b1;
          w_pix = w_head[DATA_WIDTH-1:0];
          w_nxt = RUN;
        end
      end
      RUN: begin
        if (tim_de) begin
          if (w_empty) begin
            w_pix = UNDERFLOW_COLOR;
            w_uf  = 1'b1;
            if (UNDERFLOW_MODE != 0) begin
              w_rs  = 1'b1;
              w_nxt = FLUSH;
            end
          end else if ((w_head[DATA_WIDTH+1] != tim_sof) || (w_head[DATA_WIDTH] != tim_eol)) begin
            w_pix = UNDERFLOW_COLOR;
            w_rs  = 1'b1;
            w_nxt = FLUSH;
          end else begin
            w_rd  = 1'b1;
            w_pix = w_head[DATA_WIDTH-1:0];
          end
        end
      end
      default: begin
        w_flush = 1'b1;
        w_nxt   = SEEK;
      end
    endcase
  end

  always_ff @(posedge pix_clk) begin
    if (w_wr) r_mem[r_wptr] <= {s_axis.tuser, s_axis.tlast, s_axis.tdata};
  end

  always_ff @(posedge pix_clk or posedge pix_rst) begin
    if (pix_rst) begin
      r_state    <= SEEK;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_vid_data <= '0;
      r_vid_de   <= 1'b0;
      r_vid_hs   <= 1'b0;
      r_vid_vs   <= 1'b0;
      r_locked   <= 1'b0;
      r_uf_cnt   <= '0;
      r_rs_cnt   <= '0;
      r_pix_cnt  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_wr) begin
        r_wptr    <= r_wptr + 1'b1;
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
      // Flush discards everything, including a beat accepted while the error was detected.
      if (w_flush) begin
        r_rptr  <= r_wptr;
        r_count <= '0;
      end else begin
        if (w_rd) r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
      if (w_uf && (r_uf_cnt != 16'hFFFF)) r_uf_cnt <= r_uf_cnt + 1'b1;
      if (w_rs && (r_rs_cnt != 16'hFFFF)) r_rs_cnt <= r_rs_cnt + 1'b1;
      r_vid_data <= tim_de ? w_pix : '0;
      r_vid_de   <= tim_de;
      r_vid_hs   <= tim_hs;
      r_vid_vs   <= tim_vs;
      r_locked   <= (w_nxt == RUN);
    end
  end

  assign vid_data        = r_vid_data;
  assign vid_de          = r_vid_de;
  assign vid_hs          = r_vid_hs;
  assign vid_vs          = r_vid_vs;
  assign locked          = r_locked;
  assign underflow_count = r_uf_cnt;
  assign resync_count    = r_rs_cnt;
  assign pixel_count     = r_pix_cnt;
endmodule

// File: tb/tb_axis_video_out.sv
// Directed bench for axis_video_out: one instance per underflow mode, both fed
// the same stream and timing, 4x2 active frame, 16-entry FIFO.
module tb_axis_video_out;
  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid, tuser, tlast;
  logic [15:0] tdata;
  logic        tim_de, tim_hs, tim_vs, tim_sof, tim_eol;

  logic [15:0] vd0, vd1, uf0, uf1, rs0, rs1;
  logic        de0, de1, hs0, hs1, vs0, vs1, lk0, lk1;
  logic [31:0] pc0, pc1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axis_video_out_if #(.DATA_WIDTH(16)) if0 ();
  axis_video_out_if #(.DATA_WIDTH(16)) if1 ();

  assign if0.tvalid = tvalid;  assign if1.tvalid = tvalid;
  assign if0.tdata  = tdata;   assign if1.tdata  = tdata;
  assign if0.tuser  = tuser;   assign if1.tuser  = tuser;
  assign if0.tlast  = tlast;   assign if1.tlast  = tlast;

  axis_video_out #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .UNDERFLOW_MODE(0)) dut0 (
    .pix_clk(clk), .pix_rst(rst), .s_axis(if0),
    .tim_de(tim_de), .tim_hs(tim_hs), .tim_vs(tim_vs), .tim_sof(tim_sof), .tim_eol(tim_eol),
    .vid_data(vd0), .vid_de(de0), .vid_hs(hs0), .vid_vs(vs0), .locked(lk0),
    .underflow_count(uf0), .resync_count(rs0), .pixel_count(pc0));

  axis_video_out #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .UNDERFLOW_MODE(1)) dut1 (
    .pix_clk(clk), .pix_rst(rst), .s_axis(if1),
    .tim_de(tim_de), .tim_hs(tim_hs), .tim_vs(tim_vs), .tim_sof(tim_sof), .tim_eol(tim_eol),
    .vid_data(vd1), .vid_de(de1), .vid_hs(hs1), .vid_vs(vs1), .locked(lk1),
    .underflow_count(uf1), .resync_count(rs1), .pixel_count(pc1));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [15:0] d, input logic u, input logic l);
    tvalid = 1'b1; tdata = d; tuser = u; tlast = l;
    tick();
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  // Beats 1..n; tuser on beat 1, tlast on beat eol1 and beat 8.
  task automatic load(input int n, input int eol1);
    for (int i = 1; i <= n; i++) wr(16'(i), i == 1, (i == eol1) || (i == 8));
    tick();
  endtask

  task automatic vsync();
    tim_vs = 1'b1;
    tick();
    tim_vs = 1'b0;
    chk("vs_delayed", {31'd0, vs0}, 32'd1);
    chk("de_low_in_vs", {31'd0, de0}, 32'd0);
  endtask

  // Active pixel k of the 4x2 frame; horizontal blank follows pixel 3.
  task automatic pix(input int k, input logic [15:0] e0, input logic [15:0] e1);
    tim_de = 1'b1; tim_sof = (k == 0); tim_eol = (k == 3) || (k == 7);
    tick();
    tim_de = 1'b0; tim_sof = 1'b0; tim_eol = 1'b0;
    chk($sformatf("pix0[%0d]", k), {16'd0, vd0}, {16'd0, e0});
    chk($sformatf("pix1[%0d]", k), {16'd0, vd1}, {16'd0, e1});
    if (k == 0) chk("de_delayed", {31'd0, de0}, 32'd1);
    if (k == 3) begin
      tim_hs = 1'b1;
      tick();
      tim_hs = 1'b0;
      chk("hblank_data", {16'd0, vd0}, 32'd0);
      chk("hs_delayed", {31'd0, hs0}, 32'd1);
    end
  endtask

  task automatic frame_ok();
    vsync();
    for (int k = 0; k < 8; k++) pix(k, 16'(k + 1), 16'(k + 1));
    tick();
  endtask

  initial begin
    int acc;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tuser = 1'b0; tlast = 1'b0;
    tim_de = 1'b0; tim_hs = 1'b0; tim_vs = 1'b0; tim_sof = 1'b0; tim_eol = 1'b0;
    #1;
    chk("rst_tready", {31'd0, if0.tready}, 32'd0);
    chk("rst_locked", {31'd0, lk0}, 32'd0);
    chk("rst_vid", {15'd0, vd0, de0}, 32'd0);
    do_reset();
    chk("seek_tready", {31'd0, if0.tready}, 32'd1);

    // Scenario 1: clean frame locks and streams straight through
    load(8, 4);
    chk("s1_pixcnt", pc0, 32'd8);
    chk("s1_locked_pre", {31'd0, lk0}, 32'd0);
    vsync();
    pix(0, 16'h0001, 16'h0001);
    chk("s1_locked", {30'd0, lk1, lk0}, 32'd3);
    for (int k = 1; k < 8; k++) pix(k, 16'(k + 1), 16'(k + 1));
    tick();
    chk("s1_errs", {uf0, rs0}, 32'd0);
    chk("s1_errs1", {uf1, rs1}, 32'd0);

    // Scenario 2: pre-SOF beats are dropped
    do_reset();
    for (int i = 0; i < 3; i++) wr(16'hAAA0 + 16'(i), 1'b0, 1'b0);
    load(8, 4);
    chk("s2_pixcnt", pc0, 32'd8);
    frame_ok();
    chk("s2_errs", {uf0, rs0}, 32'd0);

    // Scenario 3: stream stops after pixel 5
    do_reset();
    load(5, 4);
    vsync();
    for (int k = 0; k < 5; k++) pix(k, 16'(k + 1), 16'(k + 1));
    pix(5, 16'hF81F, 16'hF81F);
    pix(6, 16'hF81F, 16'h0000);
    pix(7, 16'hF81F, 16'h0000);
    tick();
    chk("s3_uf0", {16'd0, uf0}, 32'd3);
    chk("s3_rs0", {16'd0, rs0}, 32'd0);
    chk("s3_lk0", {31'd0, lk0}, 32'd1);
    chk("s3_uf1", {16'd0, uf1}, 32'd1);
    chk("s3_rs1", {16'd0, rs1}, 32'd1);
    chk("s3_lk1", {31'd0, lk1}, 32'd0);
    load(8, 4);
    frame_ok();
    chk("s3_relock1", {31'd0, lk1}, 32'd1);
    chk("s3_uf0_hold", {16'd0, uf0}, 32'd3);

    // Scenario 4: early tlast on line 0 forces a resync
    do_reset();
    load(8, 3);
    vsync();
    pix(0, 16'h0001, 16'h0001);
    pix(1, 16'h0002, 16'h0002);
    pix(2, 16'hF81F, 16'hF81F);
    for (int k = 3; k < 8; k++) pix(k, 16'h0000, 16'h0000);
    tick();
    chk("s4_rs", {rs1, rs0}, {16'd1, 16'd1});
    chk("s4_uf", {uf1, uf0}, 32'd0);
    chk("s4_unlocked", {30'd0, lk1, lk0}, 32'd0);
    chk("s4_tready", {31'd0, if0.tready}, 32'd1);
    load(8, 4);
    frame_ok();
    chk("s4_relock", {30'd0, lk1, lk0}, 32'd3);

    // Scenario 5: fill to full with tvalid held, then one read frees a slot
    do_reset();
    acc = 0;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      logic rdy;
      tvalid = 1'b1; tdata = 16'(acc + 1); tuser = (acc == 0); tlast = ((acc + 1) % 4) == 0;
      rdy = if0.tready;
      tick();
      if (rdy) acc++;
    end
    chk("s5_accepted", acc, 32'd16);
    tdata = 16'd17; tuser = 1'b0; tlast = 1'b0;
    tick();
    chk("s5_full_tready", {31'd0, if0.tready}, 32'd0);
    chk("s5_pixcnt", pc0, 32'd16);
    pix(0, 16'h0001, 16'h0001);
    chk("s5_tready_back", {31'd0, if0.tready}, 32'd1);
    tvalid = 1'b0;
    for (int k = 1; k < 8; k++) pix(k, 16'(k + 1), 16'(k + 1));
    chk("s5_no_loss", pc0, 32'd16);

    // Scenario 6: reset mid-line while locked
    do_reset();
    load(8, 4);
    vsync();
    for (int k = 0; k < 3; k++) pix(k, 16'(k + 1), 16'(k + 1));
    tim_de = 1'b1; tim_hs = 1'b1;
    rst = 1'b1;
    #1;
    chk("s6_vid", {15'd0, vd0, de0}, 32'd0);
    chk("s6_ctl", {28'd0, hs0, vs0, lk0, if0.tready}, 32'd0);
    chk("s6_pixcnt", pc0, 32'd0);
    tim_de = 1'b0; tim_hs = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("s6_tready", {31'd0, if0.tready}, 32'd1);
    chk("s6_cnts", {uf0, rs0}, 32'd0);
    chk("s6_locked", {31'd0, lk0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
